// File: rtl/parity_frame_ctrl_pkg.sv
// ============================================================================
// Module      : parity_frame_ctrl_pkg
// Description : Shared state encodings, output beat record and default sizing
//               for the parity frame controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package parity_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_LRC  = 2'd2
   } state_t;

   localparam int unsigned C_FRAME_LEN_DEFAULT = 8;
   localparam int unsigned C_CNT_W_DEFAULT     = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       lrc;
      logic       last;
   } beat_t;

endpackage : parity_frame_ctrl_pkg

`default_nettype wire

// File: rtl/parity_frame_ctrl_parity_bit_gen.sv
// ============================================================================
// Module      : parity_bit_gen
// Description : Even/odd parity bit for one byte.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module parity_bit_gen
   import parity_frame_ctrl_pkg::*;
(
   input  logic [7:0] data_i,
   input  logic       odd_i,
   output logic       par_o
);

   assign par_o = (^data_i) ^ odd_i;

endmodule : parity_bit_gen

`default_nettype wire

// File: rtl/parity_frame_ctrl.sv
// ============================================================================
// Module      : parity_frame_ctrl
// Description : Groups a byte stream into parity-tagged frames, closing each
//               frame with a longitudinal parity (LRC) beat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module parity_frame_ctrl
   import parity_frame_ctrl_pkg::*;
#(
   parameter int unsigned FRAME_LEN = C_FRAME_LEN_DEFAULT,
   parameter int unsigned CNT_W     = C_CNT_W_DEFAULT
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       odd_sel,
   input  logic       flush,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_par,
   output logic       out_lrc,
   output logic       out_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lrc_q, lrc_d;
   logic             odd_q, odd_d;
   beat_t            beat_q, beat_d;
   logic             out_valid_q, out_valid_d;

   logic             w_slot_free;
   logic             w_in_xfer;
   logic             w_odd_eff;
   logic             w_data_par;
   logic             w_lrc_par;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_frame_full;

   assign w_slot_free  = !out_valid_q || out_ready;
   assign w_in_xfer    = in_valid && in_ready;
   // The first byte of a frame is tagged before odd_q has captured odd_sel.
   assign w_odd_eff    = (state_q == ST_IDLE) ? odd_sel : odd_q;
   assign w_cnt_inc    = cnt_q + C_ONE;
   assign w_frame_full = (w_cnt_inc == C_LAST_CNT);

   parity_bit_gen u_data_par (
      .data_i (in_data),
      .odd_i  (w_odd_eff),
      .par_o  (w_data_par)
   );

   parity_bit_gen u_lrc_par (
      .data_i (lrc_q),
      .odd_i  (odd_q),
      .par_o  (w_lrc_par)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_in_xfer) begin
               state_d = (FRAME_LEN == 1) ? ST_LRC : ST_DATA;
            end
         end
         ST_DATA: begin
            if (flush || (w_in_xfer && w_frame_full)) begin
               state_d = ST_LRC;
            end
         end
         ST_LRC: begin
            if (w_slot_free) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = w_slot_free && (state_q != ST_LRC);
      busy     = (state_q != ST_IDLE);
   end

   always_comb begin
      cnt_d       = cnt_q;
      lrc_d       = lrc_q;
      odd_d       = odd_q;
      beat_d      = beat_q;
      out_valid_d = out_valid_q && !out_ready;
      case (state_q)
         ST_IDLE: begin
            if (w_in_xfer) begin
               odd_d       = odd_sel;
               beat_d      = '{data: in_data, par: w_data_par, lrc: 1'b0, last: 1'b0};
               out_valid_d = 1'b1;
               lrc_d       = in_data;
               cnt_d       = C_ONE;
            end
         end
         ST_DATA: begin
            if (w_in_xfer) begin
               beat_d      = '{data: in_data, par: w_data_par, lrc: 1'b0, last: 1'b0};
               out_valid_d = 1'b1;
               lrc_d       = lrc_q ^ in_data;
               cnt_d       = w_cnt_inc;
            end
         end
         ST_LRC: begin
            if (w_slot_free) begin
               beat_d      = '{data: lrc_q, par: w_lrc_par, lrc: 1'b1, last: 1'b1};
               out_valid_d = 1'b1;
               lrc_d       = 8'h00;
               cnt_d       = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         lrc_q       <= 8'h00;
         odd_q       <= 1'b0;
         beat_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         lrc_q       <= lrc_d;
         odd_q       <= odd_d;
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = beat_q.data;
   assign out_par   = beat_q.par;
   assign out_lrc   = beat_q.lrc;
   assign out_last  = beat_q.last;
   assign out_valid = out_valid_q;

endmodule : parity_frame_ctrl

`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
// ============================================================================
// Module      : tb_parity_frame_ctrl
// Description : Table-driven and scoreboard bench for parity_frame_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_parity_frame_ctrl;

   localparam int FL = 4;

   typedef struct {
      logic [7:0] d;
      logic       o;
      logic       f;
      logic       p;
      logic       hl;
      logic [7:0] ld;
      logic       lp;
      int         ew;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       odd_sel = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_par;
   logic       out_lrc;
   logic       out_last;
   logic       out_valid;
   logic       busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_act;
   vec_t        tbl[13];

   parity_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .odd_sel   (odd_sel),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_par   (out_par),
      .out_lrc   (out_lrc),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] dbeat(input logic [7:0] d, input logic p);
      return {d, p, 2'b00};
   endfunction

   function automatic logic [10:0] lbeat(input logic [7:0] d, input logic p);
      return {d, p, 2'b11};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: compare each output transfer, and the held beat while stalled.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         mon_act = {out_data, out_par, out_lrc, out_last};
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got %h expected none at %0t", mon_act, $time);
         end else if (out_ready) begin
            check("beat", mon_act, exp_q.pop_front());
         end else begin
            check("stall_hold", mon_act, exp_q[0]);
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic o, input logic f, input logic [10:0] e0,
                        input logic has_l, input logic [10:0] e1, input int ew);
      int n = 0;
      in_data  = d;
      odd_sel  = o;
      flush    = f;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got no in_ready expected accept of %h", d);
      end else begin
         exp_q.push_back(e0);
         if (has_l) exp_q.push_back(e1);
         if (ew >= 0) check("in_ready_wait", n, ew);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
      tbl[1]  = '{8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[2]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
      tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEC, 1'b1, 0};
      tbl[4]  = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
      tbl[5]  = '{8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};
      tbl[6]  = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hEC, 1'b0, 0};
      tbl[8]  = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1};
      tbl[9]  = '{8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
      tbl[10] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b1, 0};
      tbl[11] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1};
      tbl[12] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 0};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_state", {out_data, out_par, out_lrc, out_last, out_valid, busy, in_ready},
            {8'h00, 6'b000001});
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].d, tbl[i].o, tbl[i].f, dbeat(tbl[i].d, tbl[i].p),
               tbl[i].hl, lbeat(tbl[i].ld, tbl[i].lp), tbl[i].ew);
      end
      wait_drain();
      @(posedge clk);
      #1;

      // Flush with no frame open must not create a frame.
      flush = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_flush", {busy, out_valid}, 2'b00);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;

      // Flush on its own cycle after two bytes.
      drive(8'h03, 1'b0, 1'b0, dbeat(8'h03, 1'b0), 1'b0, 11'h0, 0);
      drive(8'h10, 1'b0, 1'b0, dbeat(8'h10, 1'b1), 1'b0, 11'h0, 0);
      flush = 1'b1;
      exp_q.push_back(lbeat(8'h13, 1'b1));
      @(posedge clk);
      #1;
      flush = 1'b0;
      wait_drain();
      @(posedge clk);
      #1;

      // Downstream stall for five cycles with a beat pending.
      out_ready = 1'b0;
      drive(8'h55, 1'b0, 1'b0, dbeat(8'h55, 1'b0), 1'b0, 11'h0, 0);
      fork
         drive(8'h66, 1'b0, 1'b0, dbeat(8'h66, 1'b0), 1'b0, 11'h0, -1);
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drive(8'h77, 1'b0, 1'b0, dbeat(8'h77, 1'b0), 1'b0, 11'h0, 0);
      drive(8'h07, 1'b0, 1'b0, dbeat(8'h07, 1'b1), 1'b1, lbeat(8'h43, 1'b1), 0);
      wait_drain();
      @(posedge clk);
      #1;

      // Asynchronous reset mid-frame discards the partial frame.
      drive(8'hAA, 1'b0, 1'b0, dbeat(8'hAA, 1'b0), 1'b0, 11'h0, 0);
      drive(8'hBB, 1'b0, 1'b0, dbeat(8'hBB, 1'b0), 1'b0, 11'h0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async", {out_data, out_par, out_lrc, out_last, out_valid, busy, in_ready},
            {8'h00, 6'b000001});
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(8'h01, 1'b0, 1'b0, dbeat(8'h01, 1'b1), 1'b0, 11'h0, 0);
      drive(8'h02, 1'b0, 1'b0, dbeat(8'h02, 1'b1), 1'b0, 11'h0, 0);
      drive(8'h04, 1'b0, 1'b0, dbeat(8'h04, 1'b1), 1'b0, 11'h0, 0);
      drive(8'h08, 1'b0, 1'b0, dbeat(8'h08, 1'b1), 1'b1, lbeat(8'h0F, 1'b0), 0);
      wait_drain();
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_parity_frame_ctrl

`default_nettype wire
